// File: rtl/rob_commit_unit.sv
`default_nettype none

`ifndef PHYSICAL_REG_NUM_WIDTH
`define PHYSICAL_REG_NUM_WIDTH 6
`endif
`ifndef INST_ADDR_WIDTH
`define INST_ADDR_WIDTH 32
`endif

// ============================================================================
// Module   : rob_commit_unit
// Purpose  : Reorder buffer that retires completed instructions in order.
// Revision : 1.0
// ============================================================================
module rob_commit_unit #(
  parameter int ROB_DEPTH              = 16,
  parameter int PHYSICAL_REG_NUM_WIDTH = `PHYSICAL_REG_NUM_WIDTH,
  parameter int INST_ADDR_WIDTH        = `INST_ADDR_WIDTH
) (
  input  logic                              clk,
  input  logic                              reset,
  input  logic                              alloc_valid,
  output logic                              alloc_ready,
  input  logic                              alloc_reg_wb,
  input  logic [PHYSICAL_REG_NUM_WIDTH-1:0] alloc_phy_wr_reg,
  input  logic [INST_ADDR_WIDTH-1:0]        alloc_pc,
  output logic [$clog2(ROB_DEPTH)-1:0]      alloc_tag,
  input  logic                              complete_valid,
  input  logic [$clog2(ROB_DEPTH)-1:0]      complete_tag,
  input  logic                              flush,
  output logic                              commit_valid,
  output logic                              commit_with_write,
  output logic [PHYSICAL_REG_NUM_WIDTH-1:0] commited_wr_register,
  output logic [INST_ADDR_WIDTH-1:0]        commit_pc,
  output logic [$clog2(ROB_DEPTH):0]        occupancy
);

  localparam int          TW          = $clog2(ROB_DEPTH);
  localparam logic [TW:0] DEPTH_COUNT = (TW+1)'(ROB_DEPTH);

  logic [ROB_DEPTH-1:0]              valid_q;
  logic [ROB_DEPTH-1:0]              done_q;
  logic [ROB_DEPTH-1:0]              reg_wb_q;
  logic [PHYSICAL_REG_NUM_WIDTH-1:0] phy_q [ROB_DEPTH];
  logic [INST_ADDR_WIDTH-1:0]        pc_q  [ROB_DEPTH];
  logic [TW-1:0]                     head;
  logic [TW-1:0]                     tail;
  logic [TW:0]                       count;

  logic do_alloc;
  logic do_commit;
  logic do_complete;

  assign alloc_ready = (count < DEPTH_COUNT);
  assign alloc_tag   = tail;
  assign occupancy   = count;
  assign do_alloc    = alloc_valid && alloc_ready;
  assign do_commit   = valid_q[head] && done_q[head];
  // A tag being allocated this edge is still invalid, so a same-cycle completion is dropped.
  assign do_complete = complete_valid && valid_q[complete_tag];

  always_ff @(posedge clk) begin
    if (reset || flush) begin
      valid_q      <= '0;
      done_q       <= '0;
      head         <= '0;
      tail         <= '0;
      count        <= '0;
      commit_valid <= 1'b0;
      if (reset) begin
        commit_with_write    <= 1'b0;
        commited_wr_register <= '0;
        commit_pc            <= '0;
      end
    end else begin
      commit_valid <= do_commit;
      if (do_complete) begin
        done_q[complete_tag] <= 1'b1;
      end
      // Head release is applied after completion so a retired slot always ends clear.
      if (do_commit) begin
        valid_q[head]        <= 1'b0;
        done_q[head]         <= 1'b0;
        head                 <= head + 1'b1;
        commit_with_write    <= reg_wb_q[head];
        commited_wr_register <= phy_q[head];
        commit_pc            <= pc_q[head];
      end
      if (do_alloc) begin
        valid_q[tail] <= 1'b1;
        done_q[tail]  <= 1'b0;
        tail          <= tail + 1'b1;
      end
      case ({do_alloc, do_commit})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (do_alloc) begin
      reg_wb_q[tail] <= alloc_reg_wb;
      phy_q[tail]    <= alloc_phy_wr_reg;
      pc_q[tail]     <= alloc_pc;
    end
  end

endmodule

`default_nettype wire

// File: tb/tb_rob_commit_unit.sv
`default_nettype none

`ifndef PHYSICAL_REG_NUM_WIDTH
`define PHYSICAL_REG_NUM_WIDTH 6
`endif
`ifndef INST_ADDR_WIDTH
`define INST_ADDR_WIDTH 32
`endif

// ============================================================================
// Module   : tb_rob_commit_unit
// Purpose  : Randomized and directed checks of rob_commit_unit against a queue model.
// Revision : 1.0
// ============================================================================
module tb_rob_commit_unit;

  localparam int DEPTH = 16;
  localparam int TW    = $clog2(DEPTH);
  localparam int PW    = `PHYSICAL_REG_NUM_WIDTH;
  localparam int AW    = `INST_ADDR_WIDTH;
  localparam int VW    = 1 + 1 + PW + AW + (TW + 1) + 1 + TW;

  logic          clk;
  logic          reset;
  logic          alloc_valid;
  logic          alloc_ready;
  logic          alloc_reg_wb;
  logic [PW-1:0] alloc_phy_wr_reg;
  logic [AW-1:0] alloc_pc;
  logic [TW-1:0] alloc_tag;
  logic          complete_valid;
  logic [TW-1:0] complete_tag;
  logic          flush;
  logic          commit_valid;
  logic          commit_with_write;
  logic [PW-1:0] commited_wr_register;
  logic [AW-1:0] commit_pc;
  logic [TW:0]   occupancy;

  rob_commit_unit #(
    .ROB_DEPTH              (DEPTH),
    .PHYSICAL_REG_NUM_WIDTH (PW),
    .INST_ADDR_WIDTH        (AW)
  ) dut (
    .clk                  (clk),
    .reset                (reset),
    .alloc_valid          (alloc_valid),
    .alloc_ready          (alloc_ready),
    .alloc_reg_wb         (alloc_reg_wb),
    .alloc_phy_wr_reg     (alloc_phy_wr_reg),
    .alloc_pc             (alloc_pc),
    .alloc_tag            (alloc_tag),
    .complete_valid       (complete_valid),
    .complete_tag         (complete_tag),
    .flush                (flush),
    .commit_valid         (commit_valid),
    .commit_with_write    (commit_with_write),
    .commited_wr_register (commited_wr_register),
    .commit_pc            (commit_pc),
    .occupancy            (occupancy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Reference model: program-ordered list of in-flight instructions.
  typedef struct {
    logic          wb;
    logic [PW-1:0] phy;
    logic [AW-1:0] pc;
    int            tag;
    bit            done;
  } ent_t;

  ent_t          q[$];
  int            m_tail;
  logic          m_cv;
  logic          m_wb;
  logic [PW-1:0] m_phy;
  logic [AW-1:0] m_pc;

  int n_cmp;
  int n_err;

  function automatic logic [VW-1:0] dut_vec();
    return {commit_valid, commit_with_write, commited_wr_register, commit_pc,
            occupancy, alloc_ready, alloc_tag};
  endfunction

  function automatic logic [VW-1:0] model_vec();
    return {m_cv, m_wb, m_phy, m_pc, (TW+1)'(q.size()), (q.size() < DEPTH),
            TW'(m_tail)};
  endfunction

  task automatic model_edge();
    bit cmt;
    int n;
    if (reset) begin
      q.delete();
      m_tail = 0; m_cv = 1'b0; m_wb = 1'b0; m_phy = '0; m_pc = '0;
      return;
    end
    if (flush) begin
      q.delete();
      m_tail = 0; m_cv = 1'b0;
      return;
    end
    n   = q.size();
    cmt = (n > 0) && q[0].done;
    if (complete_valid) begin
      for (int i = 0; i < q.size(); i++) begin
        if (q[i].tag == int'(complete_tag)) q[i].done = 1'b1;
      end
    end
    m_cv = cmt;
    if (cmt) begin
      m_wb  = q[0].wb;
      m_phy = q[0].phy;
      m_pc  = q[0].pc;
      void'(q.pop_front());
    end
    if (alloc_valid && n < DEPTH) begin
      q.push_back('{wb: alloc_reg_wb, phy: alloc_phy_wr_reg, pc: alloc_pc,
                    tag: m_tail, done: 1'b0});
      m_tail = (m_tail + 1) % DEPTH;
    end
  endtask

  task automatic tick();
    model_edge();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input bit av, input bit wb, input logic [PW-1:0] phy,
                       input logic [AW-1:0] pc, input bit cv,
                       input logic [TW-1:0] ct, input bit fl);
    alloc_valid      = av;
    alloc_reg_wb     = wb;
    alloc_phy_wr_reg = phy;
    alloc_pc         = pc;
    complete_valid   = cv;
    complete_tag     = ct;
    flush            = fl;
  endtask

  task automatic idle();
    drive(0, 0, '0, '0, 0, '0, 0);
  endtask

  task automatic test_reset();
    reset = 1'b1;
    idle();
    tick();
    tick();
    reset = 1'b0;
    n_cmp++;
    if (alloc_ready !== 1'b1 || occupancy !== 0 || commit_valid !== 1'b0) begin
      n_err++;
      $display("FAIL reset_state: ready=%b occ=%0d cv=%b want ready=1 occ=0 cv=0",
               alloc_ready, occupancy, commit_valid);
    end
    n_cmp++;
    if (dut_vec() !== model_vec()) begin
      n_err++;
      $display("FAIL reset_vec: got %h want %h", dut_vec(), model_vec());
    end
  endtask

  task automatic test_single();
    n_cmp++;
    if (alloc_tag !== 0) begin
      n_err++;
      $display("FAIL single_tag: got %0d want 0", alloc_tag);
    end
    drive(1, 1, 7, 'h40, 0, 0, 0);
    tick();
    drive(0, 0, '0, '0, 1, 0, 0);
    tick();
    n_cmp++;
    if (commit_valid !== 1'b0) begin
      n_err++;
      $display("FAIL single_early: commit_valid=%b want 0", commit_valid);
    end
    idle();
    tick();
    n_cmp++;
    if ({commit_valid, commit_with_write, commited_wr_register, commit_pc}
        !== {1'b1, 1'b1, PW'(7), AW'('h40)}) begin
      n_err++;
      $display("FAIL single_commit: cv=%b wb=%b reg=%0d pc=%h want 1 1 7 40",
               commit_valid, commit_with_write, commited_wr_register, commit_pc);
    end
    tick();
    n_cmp++;
    if (commit_valid !== 1'b0 || occupancy !== 0 || dut_vec() !== model_vec()) begin
      n_err++;
      $display("FAIL single_after: got %h want %h", dut_vec(), model_vec());
    end
  endtask

  task automatic test_in_order();
    drive(0, 0, '0, '0, 0, '0, 1);
    tick();
    for (int i = 0; i < 3; i++) begin
      drive(1, 1, PW'(10 + i), AW'('h100 + 4 * i), 0, '0, 0);
      tick();
    end
    for (int i = 2; i >= 0; i--) begin
      drive(0, 0, '0, '0, 1, TW'(i), 0);
      tick();
      n_cmp++;
      if (commit_valid !== 1'b0 || dut_vec() !== model_vec()) begin
        n_err++;
        $display("FAIL order_complete%0d: got %h want %h", i, dut_vec(), model_vec());
      end
    end
    idle();
    for (int i = 0; i < 3; i++) begin
      tick();
      n_cmp++;
      if (commit_valid !== 1'b1 || commit_pc !== AW'('h100 + 4 * i)) begin
        n_err++;
        $display("FAIL order_commit%0d: cv=%b pc=%h want 1 %h",
                 i, commit_valid, commit_pc, AW'('h100 + 4 * i));
      end
    end
    tick();
    n_cmp++;
    if (commit_valid !== 1'b0 || occupancy !== 0) begin
      n_err++;
      $display("FAIL order_drain: cv=%b occ=%0d want 0 0", commit_valid, occupancy);
    end
  endtask

  task automatic test_full();
    drive(0, 0, '0, '0, 0, '0, 1);
    tick();
    for (int i = 0; i < DEPTH; i++) begin
      drive(1, 1'($urandom), PW'($urandom), AW'($urandom), 0, '0, 0);
      tick();
    end
    n_cmp++;
    if (alloc_ready !== 1'b0 || occupancy !== (TW+1)'(DEPTH)) begin
      n_err++;
      $display("FAIL full_state: ready=%b occ=%0d want 0 %0d", alloc_ready, occupancy, DEPTH);
    end
    drive(1, 1, 1, 'h999, 0, '0, 0);
    tick();
    n_cmp++;
    if (occupancy !== (TW+1)'(DEPTH) || dut_vec() !== model_vec()) begin
      n_err++;
      $display("FAIL full_refuse: got %h want %h", dut_vec(), model_vec());
    end
    drive(0, 0, '0, '0, 1, 0, 0);
    tick();
    idle();
    tick();
    n_cmp++;
    if (alloc_ready !== 1'b1 || occupancy !== (TW+1)'(DEPTH - 1) || alloc_tag !== 0) begin
      n_err++;
      $display("FAIL full_release: ready=%b occ=%0d tag=%0d want 1 %0d 0",
               alloc_ready, occupancy, alloc_tag, DEPTH - 1);
    end
    drive(1, 0, 2, 'h500, 0, '0, 0);
    tick();
    n_cmp++;
    if (occupancy !== (TW+1)'(DEPTH) || alloc_tag !== 1 || dut_vec() !== model_vec()) begin
      n_err++;
      $display("FAIL full_wrap: got %h want %h", dut_vec(), model_vec());
    end
    // Commit while full: the same-edge allocation must still be refused.
    drive(0, 0, '0, '0, 1, 1, 0);
    tick();
    drive(1, 1, 3, 'h600, 0, '0, 0);
    tick();
    n_cmp++;
    if (commit_valid !== 1'b1 || occupancy !== (TW+1)'(DEPTH - 1) || dut_vec() !== model_vec()) begin
      n_err++;
      $display("FAIL full_commit_refuse: got %h want %h", dut_vec(), model_vec());
    end
    drive(0, 0, '0, '0, 1, 2, 0);
    tick();
    drive(1, 1, 4, 'h700, 0, '0, 0);
    tick();
    n_cmp++;
    if (commit_valid !== 1'b1 || occupancy !== (TW+1)'(DEPTH - 1) || dut_vec() !== model_vec()) begin
      n_err++;
      $display("FAIL alloc_commit_same: got %h want %h", dut_vec(), model_vec());
    end
  endtask

  task automatic test_store();
    drive(0, 0, '0, '0, 0, '0, 1);
    tick();
    drive(1, 0, 3, 'h80, 0, '0, 0);
    tick();
    drive(0, 0, '0, '0, 1, 0, 0);
    tick();
    idle();
    tick();
    n_cmp++;
    if (commit_valid !== 1'b1 || commit_with_write !== 1'b0 || commit_pc !== AW'('h80)) begin
      n_err++;
      $display("FAIL store_commit: cv=%b wb=%b pc=%h want 1 0 80",
               commit_valid, commit_with_write, commit_pc);
    end
  endtask

  task automatic test_flush();
    drive(0, 0, '0, '0, 0, '0, 1);
    tick();
    for (int i = 0; i < 5; i++) begin
      drive(1, 1, PW'(20 + i), AW'('h200 + 4 * i), 0, '0, 0);
      tick();
    end
    drive(0, 0, '0, '0, 1, 0, 0);
    tick();
    drive(1, 1, 9, 'hABC, 1, 1, 1);
    tick();
    n_cmp++;
    if (commit_valid !== 1'b0 || occupancy !== 0 || alloc_tag !== 0) begin
      n_err++;
      $display("FAIL flush_state: cv=%b occ=%0d tag=%0d want 0 0 0",
               commit_valid, occupancy, alloc_tag);
    end
    idle();
    tick();
    n_cmp++;
    if (commit_valid !== 1'b0 || dut_vec() !== model_vec()) begin
      n_err++;
      $display("FAIL flush_after: got %h want %h", dut_vec(), model_vec());
    end
  endtask

  task automatic test_early_complete();
    drive(0, 0, '0, '0, 0, '0, 1);
    tick();
    drive(0, 0, '0, '0, 1, 0, 0);
    tick();
    // Allocate tag 0 while completing tag 0 in the same cycle.
    drive(1, 1, 5, 'h300, 1, 0, 0);
    tick();
    idle();
    for (int i = 0; i < 3; i++) begin
      tick();
      n_cmp++;
      if (commit_valid !== 1'b0 || occupancy !== 1) begin
        n_err++;
        $display("FAIL early_wait%0d: cv=%b occ=%0d want 0 1", i, commit_valid, occupancy);
      end
    end
    drive(0, 0, '0, '0, 1, 0, 0);
    tick();
    idle();
    tick();
    n_cmp++;
    if (commit_valid !== 1'b1 || commit_pc !== AW'('h300)) begin
      n_err++;
      $display("FAIL early_commit: cv=%b pc=%h want 1 300", commit_valid, commit_pc);
    end
  endtask

  task automatic test_reset_mid();
    for (int i = 0; i < 3; i++) begin
      drive(1, 1, PW'(30 + i), AW'('h400 + 4 * i), 0, '0, 0);
      tick();
    end
    drive(0, 0, '0, '0, 1, 1, 0);
    tick();
    reset = 1'b1;
    idle();
    tick();
    reset = 1'b0;
    n_cmp++;
    if (commit_valid !== 1'b0 || occupancy !== 0 || commit_pc !== '0 || alloc_tag !== 0) begin
      n_err++;
      $display("FAIL reset_mid: cv=%b occ=%0d pc=%h tag=%0d want 0 0 0 0",
               commit_valid, occupancy, commit_pc, alloc_tag);
    end
  endtask

  task automatic test_random();
    logic [TW-1:0] ct;
    for (int cyc = 0; cyc < 800; cyc++) begin
      ct = TW'($urandom);
      if (q.size() > 0 && $urandom_range(0, 3) != 0)
        ct = TW'(q[$urandom_range(0, q.size() - 1)].tag);
      drive($urandom_range(0, 1) == 1, 1'($urandom), PW'($urandom), AW'($urandom),
            $urandom_range(0, 9) < 6, ct, $urandom_range(0, 79) == 0);
      tick();
      n_cmp++;
      if (dut_vec() !== model_vec()) begin
        n_err++;
        $display("FAIL random_c%0d: got %h want %h", cyc, dut_vec(), model_vec());
      end
    end
  endtask

  initial begin
    n_cmp  = 0;
    n_err  = 0;
    m_tail = 0;
    m_cv   = 1'b0;
    m_wb   = 1'b0;
    m_phy  = '0;
    m_pc   = '0;
    reset  = 1'b1;
    idle();
    test_reset();
    test_single();
    test_in_order();
    test_full();
    test_store();
    test_flush();
    test_early_complete();
    test_reset_mid();
    test_random();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule

`default_nettype wire

// File: doc/rob_commit_unit.md
ROB_COMMIT_UNIT -- requirements
Module: ROB_COMMIT_UNIT

Interface
REQ-001 SHALL have parameter ROB_DEPTH, default 16, entry count; power of two and at least 4.
REQ-002 SHALL have parameter PHYSICAL_REG_NUM_WIDTH, default `PHYSICAL_REG_NUM_WIDTH, physical register index width.
REQ-003 SHALL have parameter INST_ADDR_WIDTH, default `INST_ADDR_WIDTH, PC width; TW = log2(ROB_DEPTH).
REQ-004 clk  in  1  the single clock; all state updates on its rising edge.
REQ-005 reset  in  1  synchronous, active-high.
REQ-006 alloc_valid  in  1  decode presents a renamed instruction.
REQ-007 alloc_ready  out  1  buffer can accept an allocation.
REQ-008 alloc_reg_wb  in  1  the instruction writes a destination register.
REQ-009 alloc_phy_wr_reg  in  PHYSICAL_REG_NUM_WIDTH  the physical destination register.
REQ-010 alloc_pc  in  INST_ADDR_WIDTH  the instruction PC.
REQ-011 alloc_tag  out  TW  the tail index the next allocation receives.
REQ-012 complete_valid  in  1  execution reports completion.
REQ-013 complete_tag  in  TW  the entry that completed.
REQ-014 flush  in  1  discards all entries.
REQ-015 commit_valid  out  1  one-cycle pulse per retired entry.
REQ-016 commit_with_write  out  1  the retired entry had reg_wb set.
REQ-017 commited_wr_register  out  PHYSICAL_REG_NUM_WIDTH  the retired entry's physical destination register.
REQ-018 commit_pc  out  INST_ADDR_WIDTH  the retired entry's PC.
REQ-019 occupancy  out  TW+1  the number of valid entries.

Function
REQ-020 SHALL hold per entry: valid, done, reg_wb, phy_wr_reg, pc; head and tail pointers (TW bits, wrap modulo ROB_DEPTH) and a TW+1-bit count.
REQ-021 alloc_ready SHALL be (count < ROB_DEPTH), combinational from registered count only.
REQ-022 Allocation SHALL occur when alloc_valid && alloc_ready: the entry at tail is written with valid=1, done=0 and the alloc fields; tail increments.
REQ-023 alloc_valid while !alloc_ready SHALL be ignored; no state change.
REQ-024 complete_valid SHALL set done at complete_tag only if that entry is valid; otherwise it is ignored.
REQ-025 An entry allocated and completed with the same tag in the same cycle SHALL not be marked done.
REQ-026 Commit: when the head entry is valid && done at a rising edge, that edge SHALL register commit_valid=1, commit_with_write=reg_wb, commited_wr_register and commit_pc, clear the head entry and increment head; at most one commit per cycle.
REQ-027 commit_valid SHALL be 0 in any cycle following an edge with no commit; the other commit_* outputs hold their last values.
REQ-028 Latency: complete_valid sampled at edge E SHALL produce commit_valid high in the cycle after edge E+1, provided the entry is at head.
REQ-029 Retirement SHALL be strictly in allocation order; a done non-head entry waits.
REQ-030 Simultaneous alloc and commit in one edge SHALL leave count unchanged; alloc when count==ROB_DEPTH is refused even if a commit occurs that edge.
REQ-031 flush SHALL take priority over alloc, complete and commit: on the edge it is sampled, all valid/done bits clear, head=tail=count=0, and commit_valid=0 next cycle.
REQ-032 occupancy SHALL equal count.

Reset
REQ-033 With reset sampled high: head=tail=count=0, all valid/done bits 0, commit_valid=0, commit_with_write=0, commited_wr_register=0, commit_pc=0; alloc_ready=1 after reset.
REQ-034 reset asserted mid-operation SHALL discard all entries without issuing any commit pulse.

Verification
REQ-035 Allocate tag 0 (phy 7, pc 0x40, wb=1); complete tag 0 -> two cycles later one commit_valid pulse with commit_with_write=1, commited_wr_register=7, commit_pc=0x40.
REQ-036 Allocate tags 0,1,2; complete 2, then 1, then 0 -> commits in order 0,1,2 on consecutive cycles after tag 0 completes.
REQ-037 Allocate 16 entries -> alloc_ready=0 and occupancy=16; a 17th alloc_valid is ignored; commit one -> alloc_ready=1; allocate again -> tail wraps to 0.
REQ-038 Entry with wb=0 (store) -> commit pulse with commit_with_write=0.
REQ-039 With 5 entries and a completed head, assert flush -> no commit pulse, occupancy=0, and the next allocation gets alloc_tag=0.
REQ-040 complete_valid for an unallocated tag, then allocate that tag -> the entry stays not done and does not commit until completed again.
